// File: rtl/adder_seq_slice.sv
// Sequential adder: computes a+b one N-bit slice per clock through a single
// N-bit adder, publishing {cout,sum} only when the final slice completes.
module adder_seq_slice #(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         done_tick,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int S    = W / N;
    localparam int IDXW = (S > 1) ? $clog2(S) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(S - 1);

    typedef enum logic [1:0] {
        IDLE,
        OP,
        DONE
    } state_t;

    state_t          state, state_next;
    logic [W-1:0]    a_reg, b_reg, res_reg;
    logic            carry;
    logic [IDXW-1:0] idx;

    logic [N:0]      slice_res;
    logic [W-1:0]    res_merged;

    // The one shared slice adder, plus the result word with the current slice
    // patched in so the final slice can be published on the same edge.
    always_comb begin
        slice_res  = {1'b0, a_reg[int'(idx)*N +: N]}
                   + {1'b0, b_reg[int'(idx)*N +: N]}
                   + {{N{1'b0}}, carry};
        res_merged = res_reg;
        res_merged[int'(idx)*N +: N] = slice_res[N-1:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = OP;
            OP:      if (idx == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ready     = (state == IDLE);
    assign done_tick = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= 1'b0;
                        idx   <= '0;
                    end
                end
                OP: begin
                    res_reg <= res_merged;
                    carry   <= slice_res[N];
                    idx     <= idx + IDXW'(1);
                    // Outputs change only here, so partial sums never leak out.
                    if (idx == LAST) begin
                        sum  <= res_merged;
                        cout <= slice_res[N];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/adder_seq_slice.md
ADDER_SEQ_SLICE -- requirements
Module: adder_seq_slice

Interface
REQ-001 Parameter W, default 16, is the total operand/result width in bits.
REQ-002 Parameter N, default 4, is the adder slice width in bits. W SHALL be a multiple of N, and W/N SHALL be at least 2.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  request to add a and b; sampled only in IDLE.
REQ-006 a  input  W  operand A; sampled on the accepting edge.
REQ-007 b  input  W  operand B; sampled on the accepting edge.
REQ-008 ready  output  1  high only in IDLE.
REQ-009 done_tick  output  1  one-cycle pulse; result valid.
REQ-010 sum  output  W  registered result, a+b mod 2^W.
REQ-011 cout  output  1  registered carry-out of bit W-1.

Function
REQ-012 The block SHALL compute a+b one N-bit slice per clock, least-significant slice first, using a single N-bit adder with carry-in and carry-out.
REQ-013 The FSM SHALL have three states:
- IDLE -> OP on start=1.
- OP -> OP while the slice index < W/N-1.
- OP -> DONE after slice W/N-1 is processed.
- DONE -> IDLE unconditionally.
REQ-014 On the accepting edge (IDLE, start=1), the block SHALL latch a and b into internal registers, clear the carry register to 0 and clear the slice index to 0.
REQ-015 Each OP edge SHALL:
- add operand slice[idx] of A, slice[idx] of B and the carry register, giving an (N+1)-bit result;
- store the low N bits into internal result slice[idx];
- store bit N into the carry register;
- increment idx.
REQ-016 Sum and cout SHALL be loaded from the internal result and the final carry only on the OP->DONE edge, and SHALL otherwise hold their value; partial results SHALL never be visible.
REQ-017 If start is sampled at edge E, done_tick SHALL be high only in the cycle between edges E+W/N and E+W/N+1 (4 OP cycles for the defaults).
REQ-018 Done_tick SHALL be 1 only in DONE, and ready SHALL be 1 only in IDLE.
REQ-019 Start SHALL be ignored in OP and DONE, and a and b SHALL be ignored outside the accepting edge. Operand changes during OP SHALL NOT affect the result.
REQ-020 Overflow SHALL wrap: sum = (a+b) mod 2^W, and cout = 1 exactly when a+b >= 2^W.
REQ-021 Back-to-back operation: a start held high continuously SHALL be accepted on the first edge after returning to IDLE, giving one result every W/N+2 cycles.

Reset
REQ-022 When reset=1 at a rising edge, the next state SHALL be:
- state=IDLE, idx=0, carry=0;
- internal operand and result registers = 0;
- sum=0, cout=0, done_tick=0, ready=1.
REQ-023 Reset SHALL take priority over start and over any in-progress operation. A reset mid-OP SHALL abort it with no done_tick and sum/cout cleared to 0.
REQ-024 After reset is released, the first start SHALL behave exactly as after power-up.

Verification
REQ-025 a=0x1234, b=0x4321, start pulsed 1 cycle -> done_tick 4 edges later for 1 cycle, sum=0x5555, cout=0, ready low for 5 cycles.
REQ-026 a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1; the carry ripples through all four slices.
REQ-027 a=0x0FFF, b=0x0001 -> sum=0x1000, cout=0. Then, while in OP, change a/b to 0xAAAA and pulse start -> result unchanged, and exactly one done_tick occurs.
REQ-028 Start a=0x8000, b=0x8000, then assert reset for 1 cycle on the 2nd OP edge -> no done_tick, sum=0, cout=0, ready=1. A following start with a=0x0001, b=0x0002 -> sum=0x0003.
REQ-029 Start held high continuously with a=0x00FF, b=0x0001 -> done_tick every 6 cycles, sum=0x0100 each time, and sum stable between pulses.
REQ-030 Random sweep of 1000 operand pairs against a (W+1)-bit reference model -> {cout,sum} matches on every done_tick.
